dexie_trace_sink: RTL

- Receiving end of the DExIE trace interface driven by the Taiga core.
- Captures control-flow (CF) events and gated store events into one record FIFO, and presents them to a downstream policy checker over a valid/ready port.
- Drives back-pressure to the core: `stall` on high FIFO occupancy, and the stallOnStore/continueStore store-gating handshake.

---
 rtl/dexie_trace_sink.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dexie_trace_sink.sv
// DExIE trace sink: merges CF and gated store events into one record FIFO,
// presents them downstream and back-pressures the core.
module dexie_trace_sink #(
   parameter int FIFO_DEPTH   = 16,
   parameter int STALL_MARGIN = 4,
   parameter bit GATE_STORES  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cf_valid,
   input  logic [31:0] cf_cur_pc,
   input  logic [31:0] cf_cur_instruction,
   input  logic [31:0] cf_next_pc,
   input  logic [31:0] df_mem_pc,
   input  logic        df_mem_store,
   input  logic [31:0] df_mem_addr,
   input  logic [31:0] df_mem_storedata,
   input  logic        df_mem_stalling,
   output logic        stall,
   output logic        df_mem_stallOnStore,
   output logic        df_mem_continueStore,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_kind,
   output logic [31:0] out_pc,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RELEASE,
      S_DRAIN
   } state_t;

   state_t          state;
   logic [97:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW-1:0]   slot;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [97:0]     head;
   logic [97:0]     wr_data;
   logic            full;
   logic            pop;
   logic            cf_wr;
   logic            st_wr;
   logic            wr;

   assign df_mem_stallOnStore = GATE_STORES;

   assign full      = (count == DEPTH_C);
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   // a full FIFO still accepts a write when the head leaves this cycle
   assign cf_wr = cf_valid && (!full || pop);
   assign st_wr = GATE_STORES && (state == S_IDLE) && !cf_valid &&
                  df_mem_store && df_mem_stalling && (!full || pop);
   assign wr    = cf_wr || st_wr;

   assign wr_data = cf_wr ?
      {2'b01, cf_cur_pc, cf_next_pc, cf_cur_instruction} :
      {2'b10, df_mem_pc, df_mem_addr, df_mem_storedata};

   assign head     = out_valid ? mem[rptr] : '0;
   assign out_kind = head[97:96];
   assign out_pc   = head[95:64];
   assign out_a    = head[63:32];
   assign out_b    = head[31:0];

   always_comb begin
      count_next = count;
      if (wr && !pop)
         count_next = count + CW'(1);
      else if (!wr && pop)
         count_next = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         stall    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         count <= count_next;
         stall <= ((DEPTH_C - count_next) <= MARGIN_C);
         if (cf_valid && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= S_IDLE;
         slot                 <= '0;
         df_mem_continueStore <= 1'b0;
      end else begin
         df_mem_continueStore <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (st_wr) begin
                  state <= S_WAIT;
                  slot  <= wptr;
               end
            end
            S_WAIT: begin
               if (pop && (rptr == slot)) begin
                  state                <= S_RELEASE;
                  df_mem_continueStore <= 1'b1;
               end
            end
            S_RELEASE: state <= S_DRAIN;
            S_DRAIN: begin
               if (!df_mem_stalling)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
